// File: rtl/peripheral_adder_axi4_slave.sv
// AXI4-Lite slave wrapping an 8-bit adder (IN1, IN2 -> 9-bit OUT) with an optional
// sticky overflow flag/interrupt enabled by PERIPHERAL_ADDER_OVERFLOW_IRQ_EN.
module peripheral_adder_axi4_slave #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [8:0]              out,
  output logic                    irq
);

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  wr_state_e             wr_state_q, wr_state_d;
  rd_state_e             rd_state_q, rd_state_d;
  logic                  en_q;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [1:0]            aw_idx_q, aw_idx_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  wstrb0_q, wstrb0_d;
  logic [7:0]            in1_q, in1_d, in2_q, in2_d;
  logic [8:0]            out_q, sum;
  logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  aw_hs, w_hs, ar_hs, wr_fire;
  logic [1:0]            wr_idx, rd_idx;
  logic [7:0]            wr_data;
  logic                  wr_strb0;
  logic                  ovf;
  logic                  unused_bits;

  // Address/data bits outside the decoded fields are intentionally ignored.
  assign unused_bits = ^{awaddr, araddr, wdata, wstrb};

  assign sum = {1'b0, in1_q} + {1'b0, in2_q};

  // en_q keeps all ready outputs low through reset and for no longer.
  assign awready = en_q && !aw_held_q && !bvalid_q;
  assign wready  = en_q && !w_held_q && !bvalid_q;
  assign arready = en_q && (rd_state_q == RD_IDLE);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  assign wr_idx   = aw_held_q ? aw_idx_q : awaddr[3:2];
  assign wr_data  = w_held_q ? wdata_q : wdata[7:0];
  assign wr_strb0 = w_held_q ? wstrb0_q : wstrb[0];
  assign wr_fire  = (wr_state_q == WR_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign rd_idx   = araddr[3:2];

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    aw_idx_d   = aw_idx_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb0_d   = wstrb0_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          aw_idx_d  = awaddr[3:2];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = wdata[7:0];
          wstrb0_d = wstrb[0];
        end
        if (wr_fire) begin
          wr_state_d = WR_RESP;
          bvalid_d   = 1'b1;
          bresp_d    = (wr_idx == 2'd2) ? 2'b10 : 2'b00;
          if (wr_idx == 2'd0 && wr_strb0) in1_d = wr_data;
          if (wr_idx == 2'd1 && wr_strb0) in2_d = wr_data;
        end
      end
      WR_RESP: begin
        if (bready) begin
          wr_state_d = WR_IDLE;
          bvalid_d   = 1'b0;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (ar_hs) begin
          rd_state_d = RD_DATA;
          rvalid_d   = 1'b1;
          case (rd_idx)
            2'd0:    rdata_d = DATA_WIDTH'(in1_q);
            2'd1:    rdata_d = DATA_WIDTH'(in2_q);
            2'd2:    rdata_d = DATA_WIDTH'(sum);
            default: rdata_d = DATA_WIDTH'(ovf);
          endcase
        end
      end
      RD_DATA: begin
        if (rready) begin
          rd_state_d = RD_IDLE;
          rvalid_d   = 1'b0;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q       <= 1'b0;
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= 2'd0;
      w_held_q   <= 1'b0;
      wdata_q    <= 8'd0;
      wstrb0_q   <= 1'b0;
      in1_q      <= 8'd0;
      in2_q      <= 8'd0;
      out_q      <= 9'd0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      en_q       <= 1'b1;
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      aw_idx_q   <= aw_idx_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb0_q   <= wstrb0_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      out_q      <= sum;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

`ifdef PERIPHERAL_ADDER_OVERFLOW_IRQ_EN
  logic ovf_q, w1c;
  assign w1c = wr_fire && (wr_idx == 2'd3) && wr_strb0 && wr_data[0];
  // Flag on the rising edge of out[8]; a simultaneous clear loses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    ovf_q <= 1'b0;
    else if (sum[8] && !out_q[8]) ovf_q <= 1'b1;
    else if (w1c)               ovf_q <= 1'b0;
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign out    = out_q;
  assign irq    = ovf;
  assign bvalid = bvalid_q;
  assign bresp  = bresp_q;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign rresp  = 2'b00;

endmodule

// File: tb/tb_peripheral_adder_axi4_slave.sv
// Directed + randomized AXI4-Lite bench for peripheral_adder_axi4_slave with a
// register-level reference model (IN1, IN2, OVF) kept in plain variables.
module tb_peripheral_adder_axi4_slave;
  localparam int AW = 4;
  localparam int DW = 32;
`ifdef PERIPHERAL_ADDER_OVERFLOW_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic          clk, rst;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready;
  logic [8:0]    out;
  logic          irq;

  peripheral_adder_axi4_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .out(out), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_in1, m_in2;
  bit m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input int idx);
    case (idx)
      0:       return 32'(m_in1);
      1:       return 32'(m_in2);
      2:       return 32'(m_in1 + m_in2);
      default: return 32'(m_ovf);
    endcase
  endfunction

  task automatic model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
    int old_sum = m_in1 + m_in2;
    if (idx == 0 && strb[0]) m_in1 = int'(data[7:0]);
    if (idx == 1 && strb[0]) m_in2 = int'(data[7:0]);
    if (IRQ_EN && idx == 3 && strb[0] && data[0]) m_ovf = 1'b0;
    if (IRQ_EN && old_sum < 256 && (m_in1 + m_in2) >= 256) m_ovf = 1'b1;
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, input bit chk_stall);
    int  c = 0;
    bit  aw_done = 0, w_done = 0;
    logic [1:0] resp;
    while (!(aw_done && w_done) && c < 40) begin
      @(negedge clk);
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      #1;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready)   w_done = 1;
      c++;
    end
    chk("wr_handshake_done", 32'(aw_done && w_done), 1);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("bvalid_latency1", bvalid, 1);
    for (int i = 0; i < b_dly; i++) begin
      if (chk_stall) begin
        chk("stall_bvalid", bvalid, 1);
        chk("stall_awready", awready, 0);
        chk("stall_wready", wready, 0);
      end
      @(negedge clk);
    end
    bready = 1'b1;
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
    chk("bvalid_dropped", bvalid, 0);
    model_write(int'(addr[3:2]), data, strb);
    chk("bresp", resp, (addr[3:2] == 2'd2) ? 2'b10 : 2'b00);
    chk("out_port", out, 32'(m_in1 + m_in2));
    chk("irq_port", irq, m_ovf);
  endtask

  task automatic axi_read(input logic [3:0] addr, input int r_dly);
    int c = 0;
    bit done = 0;
    logic [31:0] first;
    while (!done && c < 40) begin
      @(negedge clk);
      araddr  = addr;
      arvalid = 1'b1;
      #1;
      if (arready) done = 1;
      c++;
    end
    chk("rd_handshake_done", 32'(done), 1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("rvalid_up", rvalid, 1);
    first = rdata;
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      chk("rdata_stable", rdata, first);
      chk("rvalid_held", rvalid, 1);
    end
    chk("rresp", rresp, 0);
    chk("rdata", rdata, exp_read(int'(addr[3:2])));
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rvalid_dropped", rvalid, 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_out", out, 0);
    chk("rst_irq", irq, 0);
  endtask

  initial begin
    rst = 1'b1;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    m_in1 = 0; m_in2 = 0; m_ovf = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", awready, 1);
    chk("post_rst_wready", wready, 1);
    chk("post_rst_arready", arready, 1);

    // Basic add with same-cycle AW/W
    axi_write(4'h0, 32'h5, 4'hF, 0, 0, 0, 0);
    axi_write(4'h4, 32'h2, 4'hF, 0, 0, 0, 0);
    axi_read(4'h8, 0);

    // W three cycles before AW, back-pressured response
    axi_write(4'h0, 32'h10, 4'hF, 3, 0, 4, 1);
    axi_read(4'h0, 0);

    // Read-only OUT returns SLVERR, no effect
    axi_write(4'h8, 32'h55, 4'hF, 0, 0, 0, 0);
    axi_read(4'h8, 0);

    // Byte lane 0 disabled: value must not change
    axi_write(4'h0, 32'hAA, 4'hE, 0, 1, 0, 0);
    axi_read(4'h0, 0);

    // Overflow path
    axi_write(4'h0, 32'hFF, 4'hF, 0, 0, 0, 0);
    axi_write(4'h4, 32'h01, 4'hF, 0, 0, 0, 0);
    axi_read(4'hC, 0);
    axi_write(4'hC, 32'h1, 4'hF, 0, 0, 0, 0);
    axi_read(4'hC, 0);
    axi_read(4'h8, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [3:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      a = 4'($urandom_range(0, 3) << 2);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0)
        axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 0);
      else
        axi_read(a, $urandom_range(0, 2));
    end

    // Read with rready held low, then reset during an outstanding write
    axi_write(4'h0, 32'h3C, 4'hF, 0, 0, 0, 0);
    axi_read(4'h0, 3);
    @(negedge clk);
    awaddr = 4'h4; wdata = 32'h33; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("pre_rst_bvalid", bvalid, 1);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs();
    m_in1 = 0; m_in2 = 0; m_ovf = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rec_awready", awready, 1);
    chk("rec_wready", wready, 1);
    chk("rec_arready", arready, 1);
    chk("rec_bvalid", bvalid, 0);
    axi_read(4'h0, 0);
    axi_read(4'h8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
